// File: rtl/program_loader_if.sv
// Program-load bus between the serial boot loader and the MC14500B wrapper,
// plus the loader's board-level status lines.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                    program_write;
  logic [ADDR_WIDTH+3:0]   program_cmd;
  logic                    core_hold;
  logic                    busy;
  logic                    done;
  logic                    error;

  modport master (
    output program_write,
    output program_cmd,
    output core_hold,
    output busy,
    output done,
    output error
  );

  modport slave (
    input program_write,
    input program_cmd,
    input core_hold,
    input busy,
    input done,
    input error
  );
endinterface

// File: rtl/program_loader.sv
// Serial boot loader: receives a framed program image over 8N1 UART and
// streams instruction records to the MC14500B wrapper while holding the core.
module program_loader #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 65536,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  program_loader_if.master pl
);

  localparam int unsigned CW    = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned CMD_W = ADDR_WIDTH + 4;

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_M1  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_CSUM
  } ld_state_e;

  // ---------------------------------------------------------------- sync
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------- UART
  rx_state_e    rx_state_q, rx_state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   shift_q, shift_d;
  logic         byte_valid_q, byte_valid_d;
  logic         framing_err_q, framing_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q    <= RX_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      byte_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      framing_err_q <= framing_err_d;
    end
  end

  // clk_cnt counts edges since the reference point; the edge that spots the
  // synchronized falling edge is already one edge past it, hence the load of 1.
  always_comb begin
    rx_state_d    = rx_state_q;
    clk_cnt_d     = clk_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    byte_valid_d  = 1'b0;
    framing_err_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = CW'(1);
        end
      end
      RX_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            rx_state_d   = RX_IDLE;
          end else begin
            framing_err_d = 1'b1;
            rx_state_d    = RX_WAIT;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      RX_WAIT: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // -------------------------------------------------------------- loader
  ld_state_e        state_q, state_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       sum_q, sum_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             write_q, write_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      hi_q        <= '0;
      sum_q       <= '0;
      cmd_q       <= '0;
      write_q     <= 1'b0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      hi_q        <= hi_d;
      sum_q       <= sum_d;
      cmd_q       <= cmd_d;
      write_q     <= write_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    hi_d        = hi_q;
    sum_d       = sum_q;
    cmd_d       = cmd_q;
    write_d     = 1'b0;
    hold_d      = hold_q;
    done_d      = 1'b0;
    error_d     = error_q;

    if (state_q == ST_IDLE || byte_valid_q) tmo_d = '0;
    else                                     tmo_d = tmo_q + 1'b1;

    // A byte arriving on the expiry cycle still counts as in time.
    if (state_q != ST_IDLE &&
        (framing_err_q || (!byte_valid_q && tmo_q == TMO_M1))) begin
      error_d = 1'b1;
      state_d = ST_IDLE;
    end else if (byte_valid_q) begin
      unique case (state_q)
        ST_IDLE: begin
          if (shift_q == SYNC_BYTE) begin
            hold_d  = 1'b1;
            error_d = 1'b0;
            sum_d   = '0;
            state_d = ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (shift_q == 8'd0) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            remaining_d = shift_q;
            sum_d       = sum_q + shift_q;
            state_d     = ST_HI;
          end
        end
        ST_HI: begin
          hi_d    = shift_q;
          sum_d   = sum_q + shift_q;
          state_d = ST_LO;
        end
        ST_LO: begin
          sum_d       = sum_q + shift_q;
          cmd_d       = CMD_W'({hi_q, shift_q});
          write_d     = 1'b1;
          remaining_d = remaining_q - 8'd1;
          state_d     = (remaining_q == 8'd1) ? ST_CSUM : ST_HI;
        end
        ST_CSUM: begin
          if (shift_q == sum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pl.program_write = write_q;
  assign pl.program_cmd   = cmd_q;
  assign pl.core_hold     = hold_q;
  assign pl.busy          = (state_q != ST_IDLE);
  assign pl.done          = done_q;
  assign pl.error         = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: drives UART frames on rx and checks
// writes, status and timing against expectations built from the frame contents.
module tb_program_loader;
  localparam int unsigned AW  = 8;
  localparam int unsigned CPB = 4;
  localparam int unsigned TMO = 200;
  localparam int unsigned CW  = AW + 4;
  // start drive -> 2 sync flops -> half bit -> 8 data + stop -> byte_valid -> write
  localparam int unsigned WR_LAT = 3 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(AW)) pl_if ();

  program_loader #(
    .ADDR_WIDTH  (AW),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .pl   (pl_if)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [CW-1:0] got_cmd[$];
  int unsigned   got_cyc[$];
  int            done_cnt = 0;
  int            hold_cnt = 0;
  logic [CW-1:0] exp_cmd[$];
  int unsigned   exp_cyc[$];

  always @(negedge clk) begin
    if (pl_if.program_write === 1'b1) begin
      got_cmd.push_back(pl_if.program_cmd);
      got_cyc.push_back(cyc);
    end
    if (pl_if.done === 1'b1) done_cnt++;
    if (pl_if.core_hold === 1'b1) hold_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit is_lo);
    int unsigned c0;
    @(negedge clk);
    rx = 1'b0;
    c0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (is_lo) exp_cyc.push_back(c0 + WR_LAT);
  endtask

  task automatic send_frame(input logic [7:0] noise[$], input logic [15:0] recs[$],
                            input bit corrupt);
    logic [7:0]  sum;
    logic [15:0] r;
    foreach (noise[i]) send_byte(noise[i], 1'b1, 1'b0);
    send_byte(8'hA5, 1'b1, 1'b0);
    sum = 8'(recs.size());
    send_byte(sum, 1'b1, 1'b0);
    foreach (recs[i]) begin
      r = recs[i];
      send_byte(r[15:8], 1'b1, 1'b0);
      send_byte(r[7:0], 1'b1, 1'b1);
      sum = sum + r[15:8] + r[7:0];
      exp_cmd.push_back(r[CW-1:0]);
    end
    send_byte(corrupt ? sum + 8'd1 : sum, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pl_if.program_write !== 1'b0) begin errors++; $display("FAIL rst_write got=%b exp=0", pl_if.program_write); end
    checks++; if (pl_if.program_cmd !== '0) begin errors++; $display("FAIL rst_cmd got=%h exp=000", pl_if.program_cmd); end
    checks++; if (pl_if.core_hold !== 1'b0) begin errors++; $display("FAIL rst_hold got=%b exp=0", pl_if.core_hold); end
    checks++; if (pl_if.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", pl_if.busy); end
    checks++; if (pl_if.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", pl_if.done); end
    checks++; if (pl_if.error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", pl_if.error); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (pl_if.busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got=%b exp=0", pl_if.busy); end
  endtask

  task automatic test_nominal();
    logic [7:0]  nz[$];
    logic [15:0] rc[$];
    int wb = got_cmd.size();
    int db = done_cnt;
    int hb = hold_cnt;
    exp_cmd.delete(); exp_cyc.delete();
    rc.push_back(16'h0123); rc.push_back(16'h0A05);
    send_frame(nz, rc, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (got_cmd.size() != wb + 2) begin
      errors++; $display("FAIL nom_writes got=%0d exp=2", got_cmd.size() - wb);
    end else begin
      checks++; if (got_cmd[wb] !== 12'h123) begin errors++; $display("FAIL nom_cmd0 got=%h exp=123", got_cmd[wb]); end
      checks++; if (got_cmd[wb+1] !== 12'hA05) begin errors++; $display("FAIL nom_cmd1 got=%h exp=a05", got_cmd[wb+1]); end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_cyc[wb+i] !== exp_cyc[i]) begin errors++; $display("FAIL nom_latency%0d got=%0d exp=%0d", i, got_cyc[wb+i], exp_cyc[i]); end
      end
    end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL nom_done got=%0d exp=1", done_cnt - db); end
    checks++; if (hold_cnt == hb) begin errors++; $display("FAIL nom_hold_rise got=0 exp=1"); end
    checks++; if (pl_if.core_hold !== 1'b0) begin errors++; $display("FAIL nom_hold_release got=%b exp=0", pl_if.core_hold); end
    checks++; if (pl_if.error !== 1'b0) begin errors++; $display("FAIL nom_error got=%b exp=0", pl_if.error); end
    checks++; if (pl_if.busy !== 1'b0) begin errors++; $display("FAIL nom_busy got=%b exp=0", pl_if.busy); end
  endtask

  task automatic test_bad_csum();
    logic [7:0]  nz[$];
    logic [15:0] rc[$];
    int wb = got_cmd.size();
    int db = done_cnt;
    exp_cmd.delete(); exp_cyc.delete();
    rc.push_back(16'h0123); rc.push_back(16'h0A05);
    send_frame(nz, rc, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (got_cmd.size() != wb + 2) begin errors++; $display("FAIL bad_writes got=%0d exp=2", got_cmd.size() - wb); end
    checks++; if (done_cnt != db) begin errors++; $display("FAIL bad_done got=%0d exp=0", done_cnt - db); end
    checks++; if (pl_if.error !== 1'b1) begin errors++; $display("FAIL bad_error got=%b exp=1", pl_if.error); end
    checks++; if (pl_if.core_hold !== 1'b1) begin errors++; $display("FAIL bad_hold got=%b exp=1", pl_if.core_hold); end
    send_frame(nz, rc, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (pl_if.error !== 1'b0) begin errors++; $display("FAIL bad_recover_error got=%b exp=0", pl_if.error); end
    checks++; if (pl_if.core_hold !== 1'b0) begin errors++; $display("FAIL bad_recover_hold got=%b exp=0", pl_if.core_hold); end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL bad_recover_done got=%0d exp=1", done_cnt - db); end
  endtask

  task automatic test_framing_glitch();
    logic [7:0]  nz[$];
    logic [15:0] rc[$];
    int wb = got_cmd.size();
    int db = done_cnt;
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (pl_if.error !== 1'b1) begin errors++; $display("FAIL frm_error got=%b exp=1", pl_if.error); end
    checks++; if (pl_if.busy !== 1'b0) begin errors++; $display("FAIL frm_busy got=%b exp=0", pl_if.busy); end
    checks++; if (pl_if.core_hold !== 1'b1) begin errors++; $display("FAIL frm_hold got=%b exp=1", pl_if.core_hold); end
    checks++; if (got_cmd.size() != wb) begin errors++; $display("FAIL frm_writes got=%0d exp=0", got_cmd.size() - wb); end
    // one-clock low pulse while idle must not start a byte
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (pl_if.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", pl_if.busy); end
    checks++; if (pl_if.error !== 1'b1) begin errors++; $display("FAIL glitch_error got=%b exp=1", pl_if.error); end
    exp_cmd.delete(); exp_cyc.delete();
    rc.push_back(16'h0B7E);
    send_frame(nz, rc, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (got_cmd.size() != wb + 1) begin
      errors++; $display("FAIL glitch_writes got=%0d exp=1", got_cmd.size() - wb);
    end else begin
      checks++; if (got_cmd[wb] !== 12'hB7E) begin errors++; $display("FAIL glitch_cmd got=%h exp=b7e", got_cmd[wb]); end
    end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL glitch_done got=%0d exp=1", done_cnt - db); end
  endtask

  task automatic test_idle_noise();
    logic [7:0]  nz[$];
    logic [15:0] rc[$];
    int wb = got_cmd.size();
    int db = done_cnt;
    exp_cmd.delete(); exp_cyc.delete();
    nz.push_back(8'h00); nz.push_back(8'hFF); nz.push_back(8'h12);
    rc.push_back(16'hA5A5);
    send_frame(nz, rc, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (got_cmd.size() != wb + 1) begin
      errors++; $display("FAIL noise_writes got=%0d exp=1", got_cmd.size() - wb);
    end else begin
      checks++; if (got_cmd[wb] !== 12'h5A5) begin errors++; $display("FAIL noise_cmd got=%h exp=5a5", got_cmd[wb]); end
      checks++; if (got_cyc[wb] !== exp_cyc[0]) begin errors++; $display("FAIL noise_latency got=%0d exp=%0d", got_cyc[wb], exp_cyc[0]); end
    end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL noise_done got=%0d exp=1", done_cnt - db); end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (pl_if.busy !== 1'b1) begin errors++; $display("FAIL tmo_busy_before got=%b exp=1", pl_if.busy); end
    checks++; if (pl_if.core_hold !== 1'b1) begin errors++; $display("FAIL tmo_hold_before got=%b exp=1", pl_if.core_hold); end
    repeat (250) @(negedge clk);
    checks++; if (pl_if.error !== 1'b1) begin errors++; $display("FAIL tmo_error got=%b exp=1", pl_if.error); end
    checks++; if (pl_if.busy !== 1'b0) begin errors++; $display("FAIL tmo_busy_after got=%b exp=0", pl_if.busy); end
    checks++; if (pl_if.core_hold !== 1'b1) begin errors++; $display("FAIL tmo_hold_after got=%b exp=1", pl_if.core_hold); end
  endtask

  task automatic test_count_zero();
    send_byte(8'hA5, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (pl_if.error !== 1'b0) begin errors++; $display("FAIL cz_sync_clears_error got=%b exp=0", pl_if.error); end
    checks++; if (pl_if.busy !== 1'b1) begin errors++; $display("FAIL cz_busy got=%b exp=1", pl_if.busy); end
    send_byte(8'h00, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (pl_if.error !== 1'b1) begin errors++; $display("FAIL cz_error got=%b exp=1", pl_if.error); end
    checks++; if (pl_if.busy !== 1'b0) begin errors++; $display("FAIL cz_idle got=%b exp=0", pl_if.busy); end
  endtask

  task automatic test_reset_mid();
    int wb = got_cmd.size();
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h0A, 1'b1, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (pl_if.program_write !== 1'b0) begin errors++; $display("FAIL rmid_write got=%b exp=0", pl_if.program_write); end
    checks++; if (pl_if.program_cmd !== '0) begin errors++; $display("FAIL rmid_cmd got=%h exp=000", pl_if.program_cmd); end
    checks++; if (pl_if.core_hold !== 1'b0) begin errors++; $display("FAIL rmid_hold got=%b exp=0", pl_if.core_hold); end
    checks++; if (pl_if.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", pl_if.busy); end
    checks++; if (pl_if.done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", pl_if.done); end
    checks++; if (pl_if.error !== 1'b0) begin errors++; $display("FAIL rmid_error got=%b exp=0", pl_if.error); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send_byte(8'h33, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (got_cmd.size() != wb) begin errors++; $display("FAIL rmid_writes got=%0d exp=0", got_cmd.size() - wb); end
    checks++; if (pl_if.busy !== 1'b0) begin errors++; $display("FAIL rmid_after_busy got=%b exp=0", pl_if.busy); end
  endtask

  task automatic test_random();
    logic [7:0]  nz[$];
    logic [15:0] rc[$];
    logic [7:0]  v;
    bit          corrupt;
    int          wb, db;
    for (int it = 0; it < 8; it++) begin
      nz.delete(); rc.delete();
      exp_cmd.delete(); exp_cyc.delete();
      for (int n = 0; n < int'($urandom_range(0, 3)); n++) begin
        v = 8'($urandom);
        if (v == 8'hA5) v = 8'h5A;
        nz.push_back(v);
      end
      for (int n = 0; n < int'($urandom_range(1, 4)); n++) rc.push_back(16'($urandom));
      corrupt = ($urandom_range(0, 3) == 0);
      wb = got_cmd.size();
      db = done_cnt;
      send_frame(nz, rc, corrupt);
      repeat (4) @(negedge clk);
      checks++;
      if (got_cmd.size() != wb + exp_cmd.size()) begin
        errors++; $display("FAIL rnd%0d_writes got=%0d exp=%0d", it, got_cmd.size() - wb, exp_cmd.size());
      end else begin
        foreach (exp_cmd[i]) begin
          checks++;
          if (got_cmd[wb+i] !== exp_cmd[i]) begin errors++; $display("FAIL rnd%0d_cmd%0d got=%h exp=%h", it, i, got_cmd[wb+i], exp_cmd[i]); end
          checks++;
          if (got_cyc[wb+i] !== exp_cyc[i]) begin errors++; $display("FAIL rnd%0d_latency%0d got=%0d exp=%0d", it, i, got_cyc[wb+i], exp_cyc[i]); end
        end
      end
      checks++; if (done_cnt - db != (corrupt ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_done got=%0d exp=%0d", it, done_cnt - db, corrupt ? 0 : 1); end
      checks++; if (pl_if.error !== corrupt) begin errors++; $display("FAIL rnd%0d_error got=%b exp=%b", it, pl_if.error, corrupt); end
      checks++; if (pl_if.core_hold !== corrupt) begin errors++; $display("FAIL rnd%0d_hold got=%b exp=%b", it, pl_if.core_hold, corrupt); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_csum();
    test_framing_glitch();
    test_idle_noise();
    test_timeout();
    test_count_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Serial boot loader that acts as the initiator side of the MC14500B wrapper's program-load interface.
- Receives a framed program image over a UART RX line, 8N1, LSB first, idle high.
- For each received instruction record, issues a one-cycle program_write strobe with program_cmd.
- Holds the core in reset while loading, and reports completion or error to the board.

Parameters:
- ADDR_WIDTH, 8, address field width of an instruction. Legal range 1..12.
- CLKS_PER_BIT, 434, clk cycles per UART bit. Minimum 4.
- TIMEOUT_CLKS, 65536, max idle clk cycles between bytes inside a frame.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- rx  in  1  UART serial input, asynchronous to clk
- program_write  out  1  one-cycle strobe; wrapper appends program_cmd at its next program address
- program_cmd  out  4+ADDR_WIDTH  instruction: opcode in [ADDR_WIDTH+3:ADDR_WIDTH], address in [ADDR_WIDTH-1:0]
- core_hold  out  1  level; ORed into the wrapper reset by the top level
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse on successful load
- error  out  1  sticky error flag

Behaviour:
- Reset values: program_write=0, program_cmd=0, core_hold=0, busy=0, done=0, error=0.
  - FSM in IDLE; UART in RX_IDLE; synchronizer flops =1.
  - Reset mid-frame abandons the frame with no further writes.
- Clock/reset: clk only; reset is asynchronous and active-high on every flop.
- rx passes through a 2-flop synchronizer. All UART timing below refers to the synchronized signal.
- UART receiver:
  - A falling edge in RX_IDLE starts a counter.
  - At CLKS_PER_BIT/2 the start bit is re-checked; if high, it is a glitch → return to RX_IDLE.
  - Each of the 8 data bits is sampled every CLKS_PER_BIT after that point.
  - Stop bit is sampled one further CLKS_PER_BIT later.
  - Stop=1: raise internal byte_valid for 1 cycle in the cycle after the stop sample.
  - Stop=0: raise framing_err for 1 cycle, then wait for rx high before re-arming.
- Frame format: SYNC_BYTE, COUNT, then COUNT records of {HI, LO}, then CSUM.
  - COUNT = 0 is illegal.
  - Instruction word = {HI, LO}[3+ADDR_WIDTH:0]; higher bits are ignored.
  - CSUM = 8-bit wrap-around sum of COUNT and all HI/LO bytes.
- Loader FSM states: IDLE, COUNT, HI, LO, CSUM.
  - IDLE: non-sync bytes are ignored. On SYNC_BYTE: core_hold←1, error←0, clear running sum, go to COUNT.
  - COUNT: if 0 → error; else latch the count and add it to the sum, go to HI.
  - HI: latch the byte, add to sum, go to LO.
  - LO: add to sum. In the same cycle as byte_valid, register program_cmd and assert program_write for exactly 1 cycle. Decrement remaining; if remaining becomes 0 go to CSUM, else go to HI.
  - CSUM: on match, done pulses 1 cycle, core_hold←0, go to IDLE. On mismatch → error.
- Latency: program_write is high in the clk cycle after the LO byte's byte_valid. program_cmd is stable from that cycle until the next write.
- Error entry: taken on framing_err outside IDLE, COUNT=0, CSUM mismatch, or timeout.
  - Timeout: counter reset on each byte_valid; expiry at TIMEOUT_CLKS cycles while not in IDLE.
  - On error entry: error←1 (sticky), core_hold stays 1, FSM → IDLE.
  - Writes already issued are not retracted. The core stays held until the next successful frame.
- A framing error in IDLE is ignored.
- busy = (state != IDLE).
- A SYNC_BYTE value received inside a frame is treated as data, not as a restart.
- Maximum frame: 255 records. The writer does not check program memory depth; the wrapper wraps or ignores overflow.

Test Plan (CLKS_PER_BIT=4, ADDR_WIDTH=8, TIMEOUT_CLKS=200):
- Nominal frame: send A5 02 01 23 0A 05 35 → exactly two program_write pulses, program_cmd=12'h123 then 12'hA05. Then done pulse, core_hold 1→0, error=0. Check write latency of 1 cycle after the LO stop sample.
- Bad checksum: same frame with CSUM=36 → two writes, no done, error=1, core_hold stays 1. A following good frame clears error and releases core_hold.
- Framing and glitch: stop bit 0 on the HI byte → error=1 and no write for that record. A 1-clk low glitch on rx in IDLE → no state change.
- Idle noise and data bytes: bytes 00 FF 12 before A5 are ignored. A record with HI=A5 LO=A5 is written as 12'h5A5.
- Timeout, COUNT=0, reset: stalling 250 clks after COUNT → error. Frame A5 00 → error. Asserting reset between HI and LO → all outputs reset immediately, no write.
